// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions.
// Provides the operand width, the divider FSM state encoding and the
// RISC-V divide special-case result constants. The decoder and multiplier
// import the same XLEN so the whole M-extension agrees on operand width.
package rv32m_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = $clog2(XLEN) + 1;

   // Quotient returned for a divide by zero.
   localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;
   // Most negative signed value; the only dividend that can overflow.
   localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/div_abs.sv
// Conditional two's-complement negate.
// Used to take magnitudes of signed operands and to restore the sign of
// the quotient or remainder once the unsigned iteration has finished.
// Ports:
//   value   in   XLEN  operand
//   negate  in   1     1: return -value (mod 2^XLEN), 0: pass value through
//   result  out  XLEN  conditioned value
module div_abs
   import rv32m_pkg::*;
(
   input  logic [XLEN-1:0] value,
   input  logic            negate,
   output logic [XLEN-1:0] result
);

   // -INT_MIN wraps back to INT_MIN, which read as unsigned is its magnitude.
   assign result = negate ? -value : value;

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient or remainder per accepted start. Divide-by-zero and signed
// overflow resolve in one cycle; all other requests take XLEN+2 cycles.
// Ports:
//   clk_i        in   1     clock, rising edge
//   rst_i        in   1     synchronous active-high reset
//   start_i      in   1     request strobe, accepted only in IDLE
//   signed_A_i   in   1     dividend is signed
//   signed_B_i   in   1     divisor is signed
//   upper_rem_i  in   1     0: quotient, 1: remainder
//   dividend_i   in   XLEN  rs1
//   divisor_i    in   XLEN  rs2
//   busy_o       out  1     high from the cycle after accept through done
//   done_o       out  1     one-cycle pulse, result_o valid
//   result_o     out  XLEN  result, held until overwritten by a later request
module div_unit
   import rv32m_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            signed_A_i,
   input  logic            signed_B_i,
   input  logic            upper_rem_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   div_state_e       state, next_state;

   logic [XLEN-1:0]  rem_r, quo_r, div_r, result_r;
   logic [CNT_W-1:0] count_r;
   logic             neg_quo_r, neg_rem_r, want_rem_r;

   logic             s_a, s_b, div_zero, overflow;
   logic [XLEN-1:0]  abs_a, abs_b, fix_sel, fix_val;
   logic             fix_neg;
   logic [XLEN:0]    shifted, trial;

   // Effective operand signs: only a signed operand with its MSB set is negative.
   assign s_a      = signed_A_i & dividend_i[XLEN-1];
   assign s_b      = signed_B_i & divisor_i[XLEN-1];
   assign div_zero = (divisor_i == '0);
   assign overflow = signed_A_i & signed_B_i & (dividend_i == INT_MIN) & (divisor_i == '1);

   div_abs u_abs_a (.value(dividend_i), .negate(s_a), .result(abs_a));
   div_abs u_abs_b (.value(divisor_i),  .negate(s_b), .result(abs_b));

   // Remainder takes the dividend's sign; quotient is negative when signs differ.
   assign fix_sel = want_rem_r ? rem_r     : quo_r;
   assign fix_neg = want_rem_r ? neg_rem_r : neg_quo_r;
   div_abs u_fix (.value(fix_sel), .negate(fix_neg), .result(fix_val));

   // rem < |B| is invariant, so the shifted partial remainder fits XLEN+1 bits
   // and the trial MSB is a clean borrow flag.
   assign shifted = {rem_r, quo_r[XLEN-1]};
   assign trial   = shifted - {1'b0, div_r};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= next_state;
   end

   // NOTE: every output of this block gets a default first so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      next_state = state;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      case (state)
         IDLE: if (start_i) next_state = (div_zero || overflow) ? DONE : CALC;
         CALC: begin
            busy_o = 1'b1;
            if (count_r == CNT_W'(1)) next_state = FIX;
         end
         FIX: begin
            busy_o     = 1'b1;
            next_state = DONE;
         end
         DONE: begin
            busy_o     = 1'b1;
            done_o     = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rem_r      <= '0;
         quo_r      <= '0;
         div_r      <= '0;
         result_r   <= '0;
         count_r    <= '0;
         neg_quo_r  <= 1'b0;
         neg_rem_r  <= 1'b0;
         want_rem_r <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start_i) begin
               want_rem_r <= upper_rem_i;
               if (div_zero) begin
                  result_r <= upper_rem_i ? dividend_i : DIV_ZERO_Q;
               end else if (overflow) begin
                  result_r <= upper_rem_i ? '0 : INT_MIN;
               end else begin
                  rem_r     <= '0;
                  quo_r     <= abs_a;
                  div_r     <= abs_b;
                  neg_quo_r <= s_a ^ s_b;
                  neg_rem_r <= s_a;
                  count_r   <= CNT_W'(XLEN);
               end
            end
            CALC: begin
               count_r <= count_r - CNT_W'(1);
               if (!trial[XLEN]) begin
                  rem_r <= trial[XLEN-1:0];
                  quo_r <= {quo_r[XLEN-2:0], 1'b1};
               end else begin
                  rem_r <= shifted[XLEN-1:0];
                  quo_r <= {quo_r[XLEN-2:0], 1'b0};
               end
            end
            FIX:     result_r <= fix_val;
            default: ;
         endcase
      end
   end

   assign result_o = result_r;

endmodule
